// File: rtl/counter_selector_n.sv
// N-channel step counter with channel browser, auto (prescaled) or manual increments,
// and a registered 3-digit 7-seg / LED-bar display. Define COUNTER_SEL_COUNTDOWN_EN for down-counting runs.
module counter_selector_n #(
  parameter int                  NUM_CH   = 3,
  parameter int                  LIMIT    = 100,
  parameter logic [8*NUM_CH-1:0] STEPS    = {8'd10, 8'd4, 8'd1},
  parameter int                  TICK_DIV = 50_000_000,
  parameter int                  LED_BARS = 5,
  localparam int                 CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                next_btn,
  input  logic                select_btn,
  input  logic                abort_btn,
  input  logic                mode_manual,
`ifdef COUNTER_SEL_COUNTDOWN_EN
  input  logic                count_down,
`endif
  input  logic                step_btn,
  output logic [CH_W-1:0]     ch_idx,
  output logic                busy,
  output logic                done,
  output logic [6:0]          seg_hund,
  output logic [6:0]          seg_tens,
  output logic [6:0]          seg_units,
  output logic [LED_BARS-1:0] led
);

  localparam int              PS_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(TICK_DIV - 1);
  localparam logic [9:0]      CNT_LIMIT = 10'(LIMIT);
  localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {BROWSE, RUN, DONE} state_t;

  state_t state, state_next;

  logic next_q, select_q, abort_q, step_q;
  logic next_rise, select_rise, abort_rise, step_rise;

  logic [9:0]        count [NUM_CH];
  logic [PS_W-1:0]   prescaler;
  logic              manual_q;
  logic [NUM_CH-1:0] ch_down;
  logic              start_down;

  logic [9:0]  cur_count, inc_count, end_count, progress;
  logic [10:0] sum;
  logic [7:0]  cur_step;
  logic [11:0] bcd;
  logic [LED_BARS-1:0] led_next;
  logic inc_evt, start_run, advance, abort_run, finish, bump;

  function automatic logic [11:0] to_bcd(input logic [9:0] bin);
    logic [11:0] b;
    b = '0;
    for (int i = 9; i >= 0; i--) begin
      if (b[3:0] >= 4'd5) b[3:0] = b[3:0] + 4'd3;
      if (b[7:4] >= 4'd5) b[7:4] = b[7:4] + 4'd3;
      b = {b[10:0], bin[i]};
    end
    return b;
  endfunction

  // Active-low segments ordered {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  assign next_rise   = next_btn & ~next_q;
  assign select_rise = select_btn & ~select_q;
  assign abort_rise  = abort_btn & ~abort_q;
  assign step_rise   = step_btn & ~step_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_q   <= 1'b0;
      select_q <= 1'b0;
      abort_q  <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      next_q   <= next_btn;
      select_q <= select_btn;
      abort_q  <= abort_btn;
      step_q   <= step_btn;
    end
  end

  // Direction is remembered per channel so browsing shows the right progress bar
`ifdef COUNTER_SEL_COUNTDOWN_EN
  assign start_down = count_down;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ch_down <= '0;
    else if (start_run) ch_down[ch_idx] <= count_down;
  end
`else
  assign start_down = 1'b0;
  assign ch_down    = '0;
`endif

  always_comb begin
    cur_count = count[ch_idx];
    cur_step  = STEPS[{ch_idx, 3'b000} +: 8];
    sum       = {1'b0, cur_count} + {3'b000, cur_step};
    if (ch_down[ch_idx]) begin
      inc_count = (cur_count <= {2'b00, cur_step}) ? '0 : cur_count - {2'b00, cur_step};
      end_count = '0;
    end else begin
      inc_count = (sum >= {1'b0, CNT_LIMIT}) ? CNT_LIMIT : sum[9:0];
      end_count = CNT_LIMIT;
    end
    inc_evt = manual_q ? step_rise : (prescaler == PS_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BROWSE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_run  = 1'b0;
    advance    = 1'b0;
    abort_run  = 1'b0;
    finish     = 1'b0;
    bump       = 1'b0;
    busy       = 1'b0;
    case (state)
      BROWSE: begin
        if (select_rise) begin
          start_run  = 1'b1;
          state_next = RUN;
        end else if (next_rise) begin
          advance = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort_rise) begin
          abort_run  = 1'b1;
          state_next = BROWSE;
        end else if (inc_evt) begin
          bump = 1'b1;
          if (inc_count == end_count) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (next_rise || select_rise) state_next = BROWSE;
      end
      default: state_next = BROWSE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) count[i] <= '0;
    end else if (start_run) begin
      count[ch_idx] <= start_down ? CNT_LIMIT : '0;
    end else if (abort_run) begin
      count[ch_idx] <= '0;
    end else if (bump) begin
      count[ch_idx] <= inc_count;
    end
  end

  // Prescaler only runs during an auto run, so the first tick lands TICK_DIV cycles after start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_idx    <= '0;
      prescaler <= '0;
      manual_q  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (advance) ch_idx <= (ch_idx == CH_LAST) ? '0 : ch_idx + 1'b1;
      if (start_run) manual_q <= mode_manual;
      if (state == RUN && !manual_q)
        prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;
      else
        prescaler <= '0;
    end
  end

  always_comb begin
    bcd      = to_bcd(cur_count);
    progress = ch_down[ch_idx] ? CNT_LIMIT - cur_count : cur_count;
    for (int k = 0; k < LED_BARS; k++)
      led_next[k] = (int'(progress) * LED_BARS) >= ((k + 1) * LIMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_hund  <= 7'h40;
      seg_tens  <= 7'h40;
      seg_units <= 7'h40;
      led       <= '0;
    end else begin
      seg_hund  <= seg7(bcd[11:8]);
      seg_tens  <= seg7(bcd[7:4]);
      seg_units <= seg7(bcd[3:0]);
      led       <= led_next;
    end
  end

endmodule

// File: tb/tb_counter_selector_n.sv
// Scoreboard bench for counter_selector_n: expectations are queued with the edge they are due at
// and compared by a monitor 1 time unit after that clock edge.
module tb_counter_selector_n;

  localparam int F_CH = 0, F_BUSY = 1, F_DONE = 2, F_DISP = 3, F_LED = 4;

  typedef struct {
    string tag;
    int    field;
    int    value;
    int    due;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic next_btn = 1'b0, select_btn = 1'b0, abort_btn = 1'b0, step_btn = 1'b0;
  logic mode_manual = 1'b0;
`ifdef COUNTER_SEL_COUNTDOWN_EN
  logic count_down = 1'b0;
`endif
  logic [1:0] ch_idx;
  logic       busy, done;
  logic [6:0] seg_hund, seg_tens, seg_units;
  logic [4:0] led;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  int m_ch = 0;
  bit m_done = 1'b0;
  int m_cnt[3] = '{0, 0, 0};

  counter_selector_n #(
    .NUM_CH(3), .LIMIT(10), .STEPS({8'd10, 8'd4, 8'd1}), .TICK_DIV(4), .LED_BARS(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .next_btn(next_btn),
    .select_btn(select_btn),
    .abort_btn(abort_btn),
    .mode_manual(mode_manual),
`ifdef COUNTER_SEL_COUNTDOWN_EN
    .count_down(count_down),
`endif
    .step_btn(step_btn),
    .ch_idx(ch_idx),
    .busy(busy),
    .done(done),
    .seg_hund(seg_hund),
    .seg_tens(seg_tens),
    .seg_units(seg_units),
    .led(led)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", tag, cyc, actual, expected);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int disp_exp(input int v);
    logic [20:0] d;
    d = {seg_of(v / 100), seg_of((v / 10) % 10), seg_of(v % 10)};
    return int'(d);
  endfunction

  function automatic int led_of(input int v);
    int r = 0;
    for (int k = 0; k < 5; k++)
      if (v * 5 >= (k + 1) * 10) r |= (1 << k);
    return r;
  endfunction

  function automatic int sample(input int f);
    case (f)
      F_CH:    return int'(ch_idx);
      F_BUSY:  return int'(busy);
      F_DONE:  return int'(done);
      F_DISP:  return int'({seg_hund, seg_tens, seg_units});
      default: return int'(led);
    endcase
  endfunction

  task automatic push_exp(input string tag, input int field, input int value, input int due);
    exp_t x;
    x.tag = tag;
    x.field = field;
    x.value = value;
    x.due = due;
    sb.push_back(x);
  endtask

  // Monitor: compares every queued expectation on the edge it is due
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          checkOutput(sb[i].tag, sample(sb[i].field), sb[i].value);
          sb.delete(i);
        end
      end
    end
  end

  task automatic applyStimulus(input bit nx, input bit sel, input bit ab, input bit st, output int e);
    @(negedge clk);
    next_btn   = nx;
    select_btn = sel;
    abort_btn  = ab;
    step_btn   = st;
    e = cyc + 1;
  endtask

  task automatic idle(input int n);
    int e;
    repeat (n) applyStimulus(0, 0, 0, 0, e);
  endtask

  task automatic press_next();
    int e;
    applyStimulus(1, 0, 0, 0, e);
    if (m_done) m_done = 1'b0;
    else        m_ch = (m_ch + 1) % 3;
    push_exp("browse_ch", F_CH, m_ch, e);
    push_exp("browse_busy", F_BUSY, 0, e);
    push_exp("browse_disp", F_DISP, disp_exp(m_cnt[m_ch]), e + 1);
    applyStimulus(0, 0, 0, 0, e);
  endtask

  task automatic goto_ch(input int target);
    while (m_done || m_ch != target) press_next();
  endtask

  initial begin
    int e, e0, ea;

    repeat (3) @(negedge clk);
    reset = 1'b0;

    applyStimulus(0, 0, 0, 0, e);
    push_exp("rst_ch", F_CH, 0, e);
    push_exp("rst_busy", F_BUSY, 0, e);
    push_exp("rst_done", F_DONE, 0, e);
    push_exp("rst_disp", F_DISP, disp_exp(0), e);
    push_exp("rst_led", F_LED, 0, e);

    for (int i = 0; i < 4; i++) press_next();

    // Auto run on channel 1 (step 4): 4, 8, 10 at +4, +8, +12
    mode_manual = 1'b0;
    applyStimulus(0, 1, 0, 0, e0);
    push_exp("auto_busy_start", F_BUSY, 1, e0);
    push_exp("auto_ch", F_CH, 1, e0);
    push_exp("auto_disp0", F_DISP, disp_exp(0), e0 + 4);
    push_exp("auto_done_t1", F_DONE, 0, e0 + 4);
    push_exp("auto_disp4", F_DISP, disp_exp(4), e0 + 5);
    push_exp("auto_led4", F_LED, 5'b00011, e0 + 5);
    push_exp("auto_disp4_hold", F_DISP, disp_exp(4), e0 + 8);
    push_exp("auto_done_t2", F_DONE, 0, e0 + 8);
    push_exp("auto_disp8", F_DISP, disp_exp(8), e0 + 9);
    push_exp("auto_led8", F_LED, 5'b01111, e0 + 9);
    push_exp("auto_busy_late", F_BUSY, 1, e0 + 11);
    push_exp("auto_done_early", F_DONE, 0, e0 + 11);
    push_exp("auto_done", F_DONE, 1, e0 + 12);
    push_exp("auto_busy_end", F_BUSY, 0, e0 + 12);
    push_exp("auto_done_once", F_DONE, 0, e0 + 13);
    push_exp("auto_disp10", F_DISP, disp_exp(10), e0 + 13);
    push_exp("auto_led10", F_LED, 5'b11111, e0 + 13);
    idle(14);
    m_cnt[1] = 10;
    m_done = 1'b1;

    // Select in DONE only returns to BROWSE; count must stay at 10
    applyStimulus(0, 1, 0, 0, e);
    m_done = 1'b0;
    push_exp("done_sel_busy", F_BUSY, 0, e);
    push_exp("done_sel_ch", F_CH, 1, e);
    push_exp("done_sel_disp", F_DISP, disp_exp(10), e + 1);
    push_exp("done_sel_disp_late", F_DISP, disp_exp(10), e + 4);
    push_exp("done_sel_busy_late", F_BUSY, 0, e + 4);
    idle(5);
    for (int i = 0; i < 3; i++) press_next();

    // Manual run on channel 0 (step 1); mode is changed back after start to prove latching
    goto_ch(0);
    mode_manual = 1'b1;
    applyStimulus(0, 1, 0, 0, e0);
    push_exp("man_busy", F_BUSY, 1, e0);
    push_exp("man_disp0", F_DISP, disp_exp(0), e0 + 1);
    applyStimulus(0, 0, 0, 0, e);
    mode_manual = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 0, 0, 1, e);
      push_exp("man_done", F_DONE, (i == 10) ? 1 : 0, e);
      push_exp("man_disp", F_DISP, disp_exp(i), e + 1);
      push_exp("man_led", F_LED, led_of(i), e + 1);
      if (i == 3) begin
        applyStimulus(0, 0, 0, 1, e);
        applyStimulus(0, 0, 0, 1, e);
        push_exp("man_held_step", F_DISP, disp_exp(3), e + 1);
      end
      if (i < 10) begin
        applyStimulus(1, 1, 0, 0, e);
        push_exp("man_ch_frozen", F_CH, 0, e);
        push_exp("man_busy_run", F_BUSY, 1, e);
        applyStimulus(0, 0, 0, 0, e);
      end
    end
    applyStimulus(0, 0, 0, 0, e);
    push_exp("man_busy_end", F_BUSY, 0, e);
    push_exp("man_done_once", F_DONE, 0, e);
    m_cnt[0] = 10;
    m_done = 1'b1;

    // Abort on channel 2 coinciding with the first auto tick
    goto_ch(2);
    applyStimulus(0, 1, 0, 0, e0);
    idle(3);
    applyStimulus(0, 0, 1, 0, ea);
    push_exp("abort_edge", F_CH, (ea == e0 + 4) ? 2 : 99, ea);
    push_exp("abort_busy", F_BUSY, 0, ea);
    push_exp("abort_no_done", F_DONE, 0, ea);
    push_exp("abort_no_done2", F_DONE, 0, ea + 1);
    push_exp("abort_disp", F_DISP, disp_exp(0), ea + 1);
    push_exp("abort_disp_late", F_DISP, disp_exp(0), ea + 6);
    idle(7);
    applyStimulus(0, 1, 0, 0, e0);
    push_exp("restart_busy", F_BUSY, 1, e0);
    push_exp("restart_disp0", F_DISP, disp_exp(0), e0 + 4);
    push_exp("restart_done", F_DONE, 1, e0 + 4);
    push_exp("restart_disp10", F_DISP, disp_exp(10), e0 + 5);
    push_exp("restart_led", F_LED, 5'b11111, e0 + 5);
    idle(6);
    m_cnt[2] = 10;
    m_done = 1'b1;

`ifdef COUNTER_SEL_COUNTDOWN_EN
    // Count-down run on channel 1: 10, 6, 2, 0
    goto_ch(1);
    count_down = 1'b1;
    applyStimulus(0, 1, 0, 0, e0);
    applyStimulus(0, 0, 0, 0, e);
    count_down = 1'b0;
    push_exp("down_disp10", F_DISP, disp_exp(10), e0 + 1);
    push_exp("down_led0", F_LED, 5'b00000, e0 + 1);
    push_exp("down_disp6", F_DISP, disp_exp(6), e0 + 5);
    push_exp("down_led6", F_LED, 5'b00011, e0 + 5);
    push_exp("down_disp2", F_DISP, disp_exp(2), e0 + 9);
    push_exp("down_led2", F_LED, 5'b01111, e0 + 9);
    push_exp("down_done_early", F_DONE, 0, e0 + 11);
    push_exp("down_done", F_DONE, 1, e0 + 12);
    push_exp("down_disp0", F_DISP, disp_exp(0), e0 + 13);
    push_exp("down_led_full", F_LED, 5'b11111, e0 + 13);
    idle(14);
    m_cnt[1] = 0;
    m_done = 1'b1;
`endif

    // Reset in the middle of an auto run on channel 1
    goto_ch(1);
    applyStimulus(0, 1, 0, 0, e0);
    push_exp("prereset_disp4", F_DISP, disp_exp(4), e0 + 5);
    push_exp("prereset_busy", F_BUSY, 1, e0 + 6);
    idle(6);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_ch", int'(ch_idx), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    checkOutput("async_rst_done", int'(done), 0);
    checkOutput("async_rst_disp", int'({seg_hund, seg_tens, seg_units}), disp_exp(0));
    checkOutput("async_rst_led", int'(led), 0);
    @(negedge clk);
    reset = 1'b0;
    m_ch = 0;
    m_done = 1'b0;
    m_cnt = '{0, 0, 0};
    press_next();

    idle(4);
    while (sb.size() > 0) begin
      checkOutput({"never_checked_", sb[0].tag}, -1, sb[0].value);
      sb.delete(0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
